// File: rtl/ccc_apb_cfg_master.sv
// APB initiator for the FCCC dynamic-configuration port: single read/write requests,
// BUSY-gated, with optional wait for synchronized PLL LOCK after a write.
module ccc_apb_cfg_master #(
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter int unsigned BUSY_TIMEOUT = 255
) (
  input  logic       PCLK,
  input  logic       PRESET_N,
  input  logic       REQ,
  input  logic       REQ_WRITE,
  input  logic [5:0] REQ_ADDR,
  input  logic [7:0] REQ_WDATA,
  input  logic       REQ_WAIT_LOCK,
  output logic       READY,
  output logic       ACK,
  output logic       ERR,
  output logic [7:0] RDATA,
  output logic       LOCK_STATUS,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [5:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       BUSY,
  input  logic       LOCK
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitBusy,
    StSetup,
    StAccess,
    StWaitLock,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [16:0] cnt_inc;
  logic        err_d;
  logic        wr_q, wait_lock_q;
  logic [5:0]  addr_q;
  logic [7:0]  wdata_q;
  logic        lock_meta_q;

  // One extra bit so the >= compare against a 65535 limit cannot wrap.
  assign cnt_inc = {1'b0, cnt_q} + 17'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (REQ) begin
          state_d = StWaitBusy;
          cnt_d   = '0;
        end
      end
      StWaitBusy: begin
        if (!BUSY) begin
          state_d = StSetup;
        end else if (cnt_inc >= 17'(BUSY_TIMEOUT)) begin
          state_d = StDone;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc[15:0];
        end
      end
      StSetup: state_d = StAccess;
      StAccess: begin
        if (wr_q && wait_lock_q) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else begin
          state_d = StDone;
        end
      end
      StWaitLock: begin
        if (LOCK_STATUS) begin
          state_d = StDone;
        end else if (cnt_inc >= 17'(LOCK_TIMEOUT)) begin
          state_d = StDone;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc[15:0];
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESET_N) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      wait_lock_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lock_meta_q <= 1'b0;
      LOCK_STATUS <= 1'b0;
      READY       <= 1'b1;
      ACK         <= 1'b0;
      ERR         <= 1'b0;
      RDATA       <= '0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lock_meta_q <= LOCK;
      LOCK_STATUS <= lock_meta_q;
      if (state_q == StIdle && REQ) begin
        wr_q        <= REQ_WRITE;
        wait_lock_q <= REQ_WAIT_LOCK;
        addr_q      <= REQ_ADDR;
        wdata_q     <= REQ_WDATA;
      end
      // Outputs are Moore functions of the state being entered.
      READY   <= (state_d == StIdle);
      ACK     <= (state_d == StDone);
      ERR     <= err_d;
      PSEL    <= (state_d == StSetup) || (state_d == StAccess);
      PENABLE <= (state_d == StAccess);
      if (state_d == StSetup) begin
        PWRITE <= wr_q;
        PADDR  <= addr_q;
        PWDATA <= wdata_q;
      end
      if (state_q == StAccess && !wr_q) begin
        RDATA <= PRDATA;
      end
    end
  end

endmodule

// File: tb/tb_ccc_apb_cfg_master.sv
// Scoreboard bench for ccc_apb_cfg_master: stimulus pushes expected ACKs and APB accesses
// (with the cycle they must appear on), a negedge monitor pops and compares.
module tb_ccc_apb_cfg_master;

  localparam int unsigned BT = 4;
  localparam int unsigned LT = 16;

  logic       PCLK = 1'b0;
  logic       PRESET_N = 1'b0;
  logic       REQ = 1'b0, REQ_WRITE = 1'b0, REQ_WAIT_LOCK = 1'b0;
  logic [5:0] REQ_ADDR = '0;
  logic [7:0] REQ_WDATA = '0;
  logic       READY, ACK, ERR, LOCK_STATUS, PSEL, PENABLE, PWRITE;
  logic [7:0] RDATA, PWDATA;
  logic [5:0] PADDR;
  logic [7:0] PRDATA = '0;
  logic       BUSY = 1'b0, LOCK = 1'b0;

  ccc_apb_cfg_master #(.LOCK_TIMEOUT(LT), .BUSY_TIMEOUT(BT)) dut (
    .PCLK(PCLK), .PRESET_N(PRESET_N), .REQ(REQ), .REQ_WRITE(REQ_WRITE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_WAIT_LOCK(REQ_WAIT_LOCK),
    .READY(READY), .ACK(ACK), .ERR(ERR), .RDATA(RDATA), .LOCK_STATUS(LOCK_STATUS),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .BUSY(BUSY), .LOCK(LOCK)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {int cyc; logic err; logic [7:0] rdata;} ack_t;
  typedef struct {int cyc; logic wr; logic [5:0] addr; logic [7:0] wdata;} apb_t;

  ack_t ack_q[$];
  apb_t apb_q[$];
  int   cyc = 0;
  int   n_cmp = 0, n_bad = 0;
  int   psel_cnt = 0, pen_cnt = 0;
  logic prev_setup = 1'b0;

  always @(posedge PCLK) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void push_ack(int c, logic e, logic [7:0] d);
    ack_t a;
    a.cyc = c; a.err = e; a.rdata = d;
    ack_q.push_back(a);
  endfunction

  function automatic void push_apb(int c, logic w, logic [5:0] ad, logic [7:0] wd);
    apb_t a;
    a.cyc = c; a.wr = w; a.addr = ad; a.wdata = wd;
    apb_q.push_back(a);
  endfunction

  // Monitor
  always @(negedge PCLK) begin
    if (ACK) begin
      if (ack_q.size() == 0) begin
        chk("unexpected_ack", 64'(cyc), 64'hFFFF_FFFF);
      end else begin
        ack_t a;
        a = ack_q.pop_front();
        chk("ack_cycle", 64'(cyc), 64'(a.cyc));
        chk("ack_err", 64'(ERR), 64'(a.err));
        chk("ack_rdata", 64'(RDATA), 64'(a.rdata));
      end
    end else begin
      chk("err_without_ack", 64'(ERR), 64'd0);
    end
    if (PSEL && PENABLE) begin
      if (apb_q.size() == 0) begin
        chk("unexpected_apb_access", 64'(cyc), 64'hFFFF_FFFF);
      end else begin
        apb_t p;
        p = apb_q.pop_front();
        chk("access_cycle", 64'(cyc), 64'(p.cyc));
        chk("access_after_setup", 64'(prev_setup), 64'd1);
        chk("pwrite", 64'(PWRITE), 64'(p.wr));
        chk("paddr", 64'(PADDR), 64'(p.addr));
        chk("pwdata", 64'(PWDATA), 64'(p.wdata));
      end
    end
    prev_setup = PSEL && !PENABLE;
    psel_cnt  += int'(PSEL);
    pen_cnt   += int'(PENABLE);
  end

  task automatic wait_to(int c);
    while (cyc < c) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  task automatic issue(logic w, logic [5:0] ad, logic [7:0] wd, logic wl);
    REQ = 1'b1; REQ_WRITE = w; REQ_ADDR = ad; REQ_WDATA = wd; REQ_WAIT_LOCK = wl;
    @(posedge PCLK);
    #1;
    REQ = 1'b0;
  endtask

  function automatic void chk_reset_state(string nm);
    chk(nm, 64'({READY, ACK, ERR, PSEL, PENABLE, PWRITE, LOCK_STATUS, PADDR, PWDATA, RDATA}),
        64'h1000_0000);
  endfunction

  initial begin
    int e0, p0, n0;
    logic [7:0] rdata_m;

    // Reset 3 cycles, with LOCK high to show the synchronizer stays clear.
    LOCK = 1'b1;
    repeat (3) @(posedge PCLK);
    #1;
    chk_reset_state("reset_state");
    LOCK = 1'b0;
    PRESET_N = 1'b1;
    @(posedge PCLK);
    #1;

    // Read 0x05 -> 0xA7
    PRDATA = 8'hA7; p0 = psel_cnt; n0 = pen_cnt; e0 = cyc + 1;
    push_apb(e0 + 2, 1'b0, 6'h05, 8'h11);
    push_ack(e0 + 3, 1'b0, 8'hA7);
    issue(1'b0, 6'h05, 8'h11, 1'b0);
    wait_to(e0 + 4);
    chk("ready_after_read", 64'(READY), 64'd1);
    wait_to(e0 + 5);
    chk("read_psel_cycles", 64'(psel_cnt - p0), 64'd2);
    chk("read_penable_cycles", 64'(pen_cnt - n0), 64'd1);
    rdata_m = 8'hA7;

    // Write with lock-wait; LOCK rises 10 cycles after ACCESS
    e0 = cyc + 1;
    push_apb(e0 + 2, 1'b1, 6'h12, 8'h3C);
    push_ack(e0 + 15, 1'b0, rdata_m);
    issue(1'b1, 6'h12, 8'h3C, 1'b1);
    wait_to(e0 + 12);
    LOCK = 1'b1;
    wait_to(e0 + 13);
    chk("lock_status_lag1", 64'(LOCK_STATUS), 64'd0);
    wait_to(e0 + 14);
    chk("lock_status_lag2", 64'(LOCK_STATUS), 64'd1);
    wait_to(e0 + 16);
    LOCK = 1'b0;
    wait_to(e0 + 20);
    chk("lock_status_fall", 64'(LOCK_STATUS), 64'd0);

    // Busy timeout on a read: no APB access, RDATA unchanged
    BUSY = 1'b1; p0 = psel_cnt; e0 = cyc + 1;
    push_ack(e0 + int'(BT), 1'b1, rdata_m);
    issue(1'b0, 6'h33, 8'h44, 1'b0);
    wait_to(e0 + int'(BT) + 1);
    BUSY = 1'b0;
    chk("busy_to_no_psel", 64'(psel_cnt - p0), 64'd0);
    chk("ready_after_busy_to", 64'(READY), 64'd1);

    // Lock timeout: the write still happens
    e0 = cyc + 1;
    push_apb(e0 + 2, 1'b1, 6'h2A, 8'h5E);
    push_ack(e0 + 3 + int'(LT), 1'b1, rdata_m);
    issue(1'b1, 6'h2A, 8'h5E, 1'b1);
    wait_to(e0 + 5 + int'(LT));

    // REQ pulse during ACCESS is ignored
    PRDATA = 8'h4D; e0 = cyc + 1;
    push_apb(e0 + 2, 1'b0, 6'h07, 8'h00);
    push_ack(e0 + 3, 1'b0, 8'h4D);
    issue(1'b0, 6'h07, 8'h00, 1'b0);
    wait_to(e0 + 2);
    REQ = 1'b1; REQ_WRITE = 1'b1; REQ_ADDR = 6'h3F; REQ_WDATA = 8'hEE;
    wait_to(e0 + 3);
    REQ = 1'b0;
    wait_to(e0 + 9);
    rdata_m = 8'h4D;

    // Reset during WAIT_LOCK: no ACK, everything back to reset values
    e0 = cyc + 1;
    push_apb(e0 + 2, 1'b1, 6'h15, 8'hC3);
    issue(1'b1, 6'h15, 8'hC3, 1'b1);
    wait_to(e0 + 5);
    PRESET_N = 1'b0;
    wait_to(e0 + 6);
    chk_reset_state("reset_abort_state");
    PRESET_N = 1'b1;
    wait_to(e0 + 9);

    // Back-to-back reads with REQ held high
    PRDATA = 8'h96; e0 = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      push_apb(e0 + 5 * i + 2, 1'b0, 6'h09, 8'h5A);
      push_ack(e0 + 5 * i + 3, 1'b0, 8'h96);
    end
    REQ = 1'b1; REQ_WRITE = 1'b0; REQ_ADDR = 6'h09; REQ_WDATA = 8'h5A; REQ_WAIT_LOCK = 1'b0;
    wait_to(e0 + 10);
    REQ = 1'b0;
    wait_to(e0 + 18);

    chk("ack_queue_drained", 64'(ack_q.size()), 64'd0);
    chk("apb_queue_drained", 64'(apb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
